// File: rtl/parking_lot_ctrl.sv
// Parking-lot controller: tracks spot occupancy, grants the lowest free spot on
// entry, releases a named spot on exit, flags rejected requests and drives a
// retriggerable door-open timer.
//
// Request/response semantics: enter_req and exit_req are single-cycle strobes
// with no back-pressure. Each strobe sampled at a rising edge produces exactly
// one registered response visible after that same edge: alloc_valid or
// reject_full for an entry, a cleared occupancy bit or reject_exit for an exit.
module parking_lot_ctrl #(
    parameter int NUM_SPOTS   = 8,
    parameter int DOOR_CYCLES = 4,
    localparam int SPOT_W     = $clog2(NUM_SPOTS),
    localparam int CNT_W      = $clog2(NUM_SPOTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enter_req,
    input  logic                 exit_req,
    input  logic [SPOT_W-1:0]    exit_spot,
    output logic [NUM_SPOTS-1:0] occupancy,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic                 alloc_valid,
    output logic [SPOT_W-1:0]    alloc_spot,
    output logic                 reject_full,
    output logic                 reject_exit,
    output logic                 door_open
);

    // Occupancy padded to every index exit_spot can encode; the padding bits
    // are always zero, so an out-of-range exit simply sees a free spot.
    localparam int IDX_N = 1 << SPOT_W;
    localparam int TMR_W = $clog2(DOOR_CYCLES + 1);

    typedef enum logic {
        CLOSED = 1'b0,
        OPEN   = 1'b1
    } door_state_t;

    door_state_t          state_q, state_n;
    logic [TMR_W-1:0]     timer_q, timer_n;

    logic [IDX_N-1:0]     occ_ext;
    logic [IDX_N-1:0]     occ_nxt_ext;
    logic [SPOT_W-1:0]    free_idx;
    logic                 lot_full;
    logic                 alloc_ok;
    logic                 exit_ok;
    logic                 accepted;
    logic [CNT_W-1:0]     count_n;

    // Decide entry/exit outcomes against the pre-edge occupancy.
    always_comb begin
        occ_ext  = IDX_N'(occupancy);
        lot_full = &occupancy;
        alloc_ok = enter_req && !lot_full;
        exit_ok  = exit_req && occ_ext[exit_spot];
        accepted = alloc_ok || exit_ok;

        // Scan downwards so the lowest free index wins.
        free_idx = '0;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                free_idx = SPOT_W'(i);
            end
        end

        // free_idx is always an occupied-before-edge-free spot, so it can
        // never coincide with the spot released in the same cycle.
        occ_nxt_ext = occ_ext;
        if (alloc_ok) begin
            occ_nxt_ext[free_idx] = 1'b1;
        end
        if (exit_ok) begin
            occ_nxt_ext[exit_spot] = 1'b0;
        end

        case ({alloc_ok, exit_ok})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
    end

    // Occupancy, count, status flags and response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy   <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            alloc_valid <= 1'b0;
            alloc_spot  <= '0;
            reject_full <= 1'b0;
            reject_exit <= 1'b0;
        end else begin
            occupancy   <= occ_nxt_ext[NUM_SPOTS-1:0];
            count       <= count_n;
            full        <= (count_n == CNT_W'(NUM_SPOTS));
            empty       <= (count_n == '0);
            alloc_valid <= alloc_ok;
            alloc_spot  <= alloc_ok ? free_idx : '0;
            reject_full <= enter_req && lot_full;
            reject_exit <= exit_req && !exit_ok;
        end
    end

    // Door FSM state and timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLOSED;
            timer_q <= '0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
        end
    end

    // Door FSM next state: any accepted event (re)loads the hold timer.
    always_comb begin
        state_n = state_q;
        timer_n = timer_q;
        if (accepted) begin
            state_n = OPEN;
            timer_n = TMR_W'(DOOR_CYCLES - 1);
        end else if (state_q == OPEN) begin
            if (timer_q == '0) begin
                state_n = CLOSED;
            end else begin
                timer_n = timer_q - TMR_W'(1);
            end
        end
    end

    assign door_open = (state_q == OPEN);

endmodule
